// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-input arbitrating multiplexer.
// Holds the output-register state encoding, default data width and statistics counter width.
package mux_pkg;

   localparam int DATA_W = 5;
   localparam int CNT_W  = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   // Saturating increment used by the optional grant counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == {CNT_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Handshake bundle between two sources, the arbiter and the downstream sink.
// The slave modport is the arbiter view; the master modport is the environment view.
interface mux_arbiter_if #(parameter int n = 5);

   logic [n-1:0] in0;
   logic         in0_valid;
   logic         in0_ready;
   logic [n-1:0] in1;
   logic         in1_valid;
   logic         in1_ready;
   logic         sel;
   logic [n-1:0] mux_out;
   logic         out_valid;
   logic         out_ready;

   modport slave (
      input  in0, in0_valid, in1, in1_valid, out_ready,
      output in0_ready, in1_ready, sel, mux_out, out_valid
   );

   modport master (
      output in0, in0_valid, in1, in1_valid, out_ready,
      input  in0_ready, in1_ready, sel, mux_out, out_valid
   );

endinterface

// File: rtl/mux_arbiter_multiplexor.sv
// Plain combinational 2:1 selector: sel_i = 0 passes in0_i, sel_i = 1 passes in1_i.
module Multiplexor #(parameter int n = 5) (
   input  logic [n-1:0] in0_i,
   input  logic [n-1:0] in1_i,
   input  logic         sel_i,
   output logic [n-1:0] out_o
);

   assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output stage.
// Define MUX_ARBITER_STATS_EN to add saturating per-source grant counters.
module mux_arbiter
   import mux_pkg::*;
#(
   parameter int n = DATA_W
) (
   input  logic clk,
   input  logic rst,
   mux_arbiter_if.slave bus
`ifdef MUX_ARBITER_STATS_EN
   ,
   output logic [CNT_W-1:0] grant0_cnt,
   output logic [CNT_W-1:0] grant1_cnt
`endif
);

   state_e       state_q, state_d;
   logic [n-1:0] mux_out_q, mux_out_d;
   logic         last_q, last_d;
   logic         can_load_s;
   logic         sel_s;
   logic         xfer_s;
   logic [n-1:0] mux_y_s;

   Multiplexor #(.n(n)) u_mux (
      .in0_i (bus.in0),
      .in1_i (bus.in1),
      .sel_i (sel_s),
      .out_o (mux_y_s)
   );

   // Grant logic: alternate on contention, otherwise follow whichever source is valid.
   always_comb begin
      can_load_s = (state_q == EMPTY) | bus.out_ready;
      if (bus.in0_valid && bus.in1_valid) begin
         sel_s = ~last_q;
      end else if (bus.in1_valid) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
      xfer_s = can_load_s & (bus.in0_valid | bus.in1_valid) & ~rst;
   end

   assign bus.sel       = sel_s;
   assign bus.in0_ready = can_load_s & bus.in0_valid & ~sel_s & ~rst;
   assign bus.in1_ready = can_load_s & bus.in1_valid &  sel_s & ~rst;
   assign bus.mux_out   = mux_out_q;
   assign bus.out_valid = (state_q == FULL);

   // Next-state and data-path update for the output register.
   always_comb begin
      state_d   = state_q;
      mux_out_d = mux_out_q;
      last_d    = last_q;
      if (xfer_s) begin
         mux_out_d = mux_y_s;
         last_d    = sel_s;
      end else begin
         mux_out_d = mux_out_q;
         last_d    = last_q;
      end
      case (state_q)
         EMPTY: begin
            if (xfer_s) begin
               state_d = FULL;
            end else begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (xfer_s) begin
               state_d = FULL;
            end else if (bus.out_ready) begin
               state_d = EMPTY;
            end else begin
               state_d = FULL;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // State registers; last resets to 1 so in0 wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         mux_out_q <= {n{1'b0}};
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         mux_out_q <= mux_out_d;
         last_q    <= last_d;
      end
   end

`ifdef MUX_ARBITER_STATS_EN
   logic [CNT_W-1:0] grant0_cnt_q, grant1_cnt_q;

   // Per-source transfer counters, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant0_cnt_q <= {CNT_W{1'b0}};
         grant1_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (xfer_s && !sel_s) begin
            grant0_cnt_q <= sat_inc(grant0_cnt_q);
         end
         if (xfer_s && sel_s) begin
            grant1_cnt_q <= sat_inc(grant1_cnt_q);
         end
      end
   end

   assign grant0_cnt = grant0_cnt_q;
   assign grant1_cnt = grant1_cnt_q;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter: reset, alternation, backpressure, drain, mid-stream reset.
module tb_mux_arbiter;
   import mux_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mux_arbiter_if #(.n(DATA_W)) ifc ();

`ifdef MUX_ARBITER_STATS_EN
   logic [CNT_W-1:0] grant0_cnt;
   logic [CNT_W-1:0] grant1_cnt;
`endif

   mux_arbiter #(.n(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
`ifdef MUX_ARBITER_STATS_EN
      ,
      .grant0_cnt (grant0_cnt),
      .grant1_cnt (grant1_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst           = 1'b1;
      ifc.in0       = 5'b00000;
      ifc.in1       = 5'b00000;
      ifc.in0_valid = 1'b1;
      ifc.in1_valid = 1'b0;
      ifc.out_ready = 1'b1;

      // Reset state, with a valid source present.
      #2;
      check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("rst_mux_out",   32'(ifc.mux_out),   32'd0);
      check("rst_in0_ready", 32'(ifc.in0_ready), 32'd0);
      check("rst_in1_ready", 32'(ifc.in1_ready), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Single in0 transfer.
      ifc.in0       = 5'b10101;
      ifc.in0_valid = 1'b1;
      ifc.in1_valid = 1'b0;
      ifc.out_ready = 1'b1;
      #2;
      check("t1_in0_ready", 32'(ifc.in0_ready), 32'd1);
      check("t1_in1_ready", 32'(ifc.in1_ready), 32'd0);
      check("t1_sel",       32'(ifc.sel),       32'd0);
      tick();
      check("t1_mux_out",   32'(ifc.mux_out),   32'h15);
      check("t1_out_valid", 32'(ifc.out_valid), 32'd1);

      // Strict alternation under contention.
      do_reset();
      ifc.in0       = 5'b01010;
      ifc.in1       = 5'b10101;
      ifc.in0_valid = 1'b1;
      ifc.in1_valid = 1'b1;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         check("t2_sel",       32'(ifc.sel),       32'(i % 2));
         check("t2_in0_ready", 32'(ifc.in0_ready), 32'((i % 2) == 0));
         check("t2_in1_ready", 32'(ifc.in1_ready), 32'((i % 2) == 1));
         tick();
         check("t2_mux_out",   32'(ifc.mux_out),   ((i % 2) == 0) ? 32'h0A : 32'h15);
         check("t2_out_valid", 32'(ifc.out_valid), 32'd1);
      end

      // Backpressure while FULL with 10101; both sources stay valid.
      ifc.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t3_in0_ready", 32'(ifc.in0_ready), 32'd0);
         check("t3_in1_ready", 32'(ifc.in1_ready), 32'd0);
         tick();
         check("t3_mux_out",   32'(ifc.mux_out),   32'h15);
         check("t3_out_valid", 32'(ifc.out_valid), 32'd1);
      end
      ifc.out_ready = 1'b1;
      #2;
      check("t3_rel_in0_ready", 32'(ifc.in0_ready), 32'd1);
      tick();
      check("t3_rel_mux_out",   32'(ifc.mux_out),   32'h0A);

      // Drain with no input valid: goes EMPTY, data retained.
      ifc.in0_valid = 1'b0;
      ifc.in1_valid = 1'b0;
      #2;
      check("t4_in0_ready", 32'(ifc.in0_ready), 32'd0);
      check("t4_sel",       32'(ifc.sel),       32'd0);
      tick();
      check("t4_out_valid", 32'(ifc.out_valid), 32'd0);
      check("t4_mux_out",   32'(ifc.mux_out),   32'h0A);

      // EMPTY accepts even with out_ready low; in1-only grant.
      ifc.out_ready = 1'b0;
      ifc.in1_valid = 1'b1;
      #2;
      check("t4b_sel",       32'(ifc.sel),       32'd1);
      check("t4b_in1_ready", 32'(ifc.in1_ready), 32'd1);
      tick();
      check("t4b_mux_out",   32'(ifc.mux_out),   32'h15);
      check("t4b_out_valid", 32'(ifc.out_valid), 32'd1);

      // Asynchronous reset mid-stream while FULL.
      ifc.in0_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("t5_out_valid", 32'(ifc.out_valid), 32'd0);
      check("t5_mux_out",   32'(ifc.mux_out),   32'd0);
      check("t5_in0_ready", 32'(ifc.in0_ready), 32'd0);
      check("t5_in1_ready", 32'(ifc.in1_ready), 32'd0);
      tick();
      rst = 1'b0;
      ifc.out_ready = 1'b1;
      #2;
      check("t5_sel",       32'(ifc.sel),       32'd0);
      check("t5_in0_ready", 32'(ifc.in0_ready), 32'd1);
      tick();
      check("t5_mux_out",   32'(ifc.mux_out),   32'h0A);

`ifdef MUX_ARBITER_STATS_EN
      // Counter saturation with in1-only traffic.
      do_reset();
      ifc.in0_valid = 1'b0;
      ifc.in1_valid = 1'b1;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
      end
      ifc.in1_valid = 1'b0;
      tick();
      check("t6_grant1_cnt", 32'(grant1_cnt), 32'd255);
      check("t6_grant0_cnt", 32'(grant0_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter n, default 5, data width of each input and the output.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in0  input  n  data of source 0.
REQ-005 SHALL have port in0_valid  input  1  source 0 offers in0.
REQ-006 SHALL have port in0_ready  output  1  source 0 transfer accepted this cycle.
REQ-007 SHALL have port in1  input  n  data of source 1.
REQ-008 SHALL have port in1_valid  input  1  source 1 offers in1.
REQ-009 SHALL have port in1_ready  output  1  source 1 transfer accepted this cycle.
REQ-010 SHALL have port sel  output  1  current combinational grant: 0 = in0, 1 = in1.
REQ-011 SHALL have port mux_out  output  n  registered output data.
REQ-012 SHALL have port out_valid  output  1  mux_out holds an undelivered word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts mux_out this cycle.

Function
REQ-014 SHALL hold a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL compute can_load = !out_valid | out_ready.
REQ-016 SHALL compute sel: both valid -> !last; only in1_valid -> 1; otherwise -> 0.
REQ-017 SHALL drive in0_ready = can_load & in0_valid & (sel==0) and in1_ready = can_load & in1_valid & (sel==1); at most one is high per cycle.
REQ-018 SHALL, on a cycle with an input transfer, load mux_out with the granted input and set out_valid=1 at the next edge (latency 1 cycle).
REQ-019 SHALL update last to sel only on cycles with an input transfer; no transfer -> last unchanged.
REQ-020 SHALL, in FULL with out_ready=1 and no input transfer, go to EMPTY; mux_out keeps its value.
REQ-021 SHALL, in FULL with out_ready=1 and an input transfer, stay FULL and load new data in the same edge (back-to-back, one word per cycle).
REQ-022 SHALL, in FULL with out_ready=0, hold mux_out and out_valid stable and deassert both in*_ready.
REQ-023 SHALL never drop or duplicate a word; neither input is starved when both stay valid (strict alternation).

Reset
REQ-024 SHALL on rst=1 immediately force out_valid=0, mux_out=0, last=1 (in0 wins first contention), state EMPTY.
REQ-025 SHALL discard any word held in the output register when reset asserts mid-operation.
REQ-026 SHALL, while rst=1, drive in0_ready=0 and in1_ready=0.

Configuration
REQ-027 SHALL, when macro MUX_ARBITER_STATS_EN is defined, add outputs grant0_cnt and grant1_cnt (8 bits each) counting input transfers per source, saturating at 255, reset to 0.
REQ-028 SHALL, when MUX_ARBITER_STATS_EN is undefined, have no counter ports or logic; all other behaviour identical.

Structure
REQ-029 SHALL place the state encoding (EMPTY=0, FULL=1), the default width 5 and the counter width 8 in shared package mux_pkg.
REQ-030 SHALL instantiate the existing 2:1 module Multiplexor (parameter n) as the one sub-module, with sel as its select and its output feeding the mux_out register.

Verification
REQ-031 SHALL cover: reset, then in0=10101 valid only, out_ready=1 -> in0_ready=1, sel=0; next cycle mux_out=10101, out_valid=1.
REQ-032 SHALL cover: in0=01010 and in1=10101 both valid 4 cycles, out_ready=1 -> sel 0,1,0,1; mux_out 01010,10101,01010,10101 one per cycle.
REQ-033 SHALL cover: FULL with mux_out=10101, out_ready=0 for 3 cycles, both valid -> mux_out stable, in0_ready=in1_ready=0; out_ready=1 -> next word loaded one cycle later.
REQ-034 SHALL cover: FULL, out_ready=1, no input valid -> out_valid=0 next cycle, mux_out unchanged.
REQ-035 SHALL cover: rst asserted mid-stream while FULL -> out_valid=0, mux_out=00000 without a clock edge; first contention after release grants in0.
REQ-036 SHALL cover with MUX_ARBITER_STATS_EN: 300 in1-only transfers -> grant1_cnt=255, grant0_cnt=0.
